uart_rx_byte_buffer: RTL

//  Downstream datapath for the UART receive control FSM. Samples the serial line on each

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_sync_fifo.sv | 82 ++++++++
 rtl/uart_rx_byte_buffer.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive byte buffer.
// Payload width, byte type and receive status encoding.
package uart_rx_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

   typedef enum logic [1:0] {
      RX_OK        = 2'd0,
      RX_FRAME_ERR = 2'd1,
      RX_OVERRUN   = 2'd2
   } uart_rx_status_e;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous FIFO with a registered head output (no fall-through).
// A full FIFO still accepts a push when a pop happens in the same cycle.
module uart_rx_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         dout
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_next;
   logic             push_ok;
   logic             pop_ok;
   logic [WIDTH-1:0] dout_next;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == (AW+1)'(0));

   // Accepted push/pop and the head value for the next cycle
   always_comb begin
      pop_ok    = pop & ~empty;
      push_ok   = push & (~full | pop_ok);
      rd_next   = rd_ptr + AW'(1);
      dout_next = dout;
      if (pop_ok) begin
         if (count > (AW+1)'(1)) begin
            dout_next = mem[rd_next];
         end else if (push_ok) begin
            dout_next = din;
         end else begin
            dout_next = dout;
         end
      end else if (push_ok && empty) begin
         dout_next = din;
      end else begin
         dout_next = dout;
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and registered head
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= AW'(0);
         rd_ptr <= AW'(0);
         count  <= (AW+1)'(0);
         dout   <= WIDTH'(0);
      end else begin
         dout <= dout_next;
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_next;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_byte_buffer.sv
// UART receive datapath: LSB-first shift register, bit-count frame check, byte FIFO.
// Define RX_OVERRUN_STICKY_EN to make overrun sticky until ovr_clr.
module uart_rx_byte_buffer
   import uart_rx_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS,
   parameter int DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_bit,
   input  logic                     shift_rx,
   input  logic                     data_rx,
   output logic [DATA_BITS-1:0]     rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     frame_err,
   output logic                     overrun,
   input  logic                     ovr_clr
);

   localparam int CW = $clog2(DATA_BITS + 2);

   logic [DATA_BITS-1:0] sr;
   logic [CW-1:0]        bit_cnt;
   logic                 push;
   logic                 bad_frame;
   logic                 refused;
   logic                 full;
   logic                 empty;

   assign push      = data_rx & (bit_cnt == CW'(DATA_BITS));
   assign bad_frame = data_rx & (bit_cnt != CW'(DATA_BITS));
   // A full FIFO only refuses when no pop frees a slot in the same cycle
   assign refused   = push & full & ~rd_ready;
   assign rd_valid  = ~empty;

   // Shift register and saturating bit counter; the done cycle never shifts
   always_ff @(posedge clk) begin
      if (reset) begin
         sr      <= DATA_BITS'(0);
         bit_cnt <= CW'(0);
      end else if (data_rx) begin
         bit_cnt <= CW'(0);
      end else if (shift_rx) begin
         sr <= {rx_bit, sr[DATA_BITS-1:1]};
         if (bit_cnt != CW'(DATA_BITS + 1)) begin
            bit_cnt <= bit_cnt + CW'(1);
         end
      end
   end

   // Frame error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_err <= 1'b0;
      end else begin
         frame_err <= bad_frame;
      end
   end

`ifdef RX_OVERRUN_STICKY_EN
   // Sticky overrun; clear wins over a same-cycle set
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (ovr_clr) begin
         overrun <= 1'b0;
      end else if (refused) begin
         overrun <= 1'b1;
      end
   end
`else
   logic unused_ovr_clr;
   assign unused_ovr_clr = ovr_clr;

   // Overrun pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun <= 1'b0;
      end else begin
         overrun <= refused;
      end
   end
`endif

   uart_rx_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (rd_ready),
      .din   (sr),
      .full  (full),
      .empty (empty),
      .count (fifo_count),
      .dout  (rd_data)
   );

endmodule
